// File: rtl/ram_sampler.sv
// ram_sampler: synchronizes an asynchronous PSRAM bus into mclk, filters
// ram_clk edges against glitches, and presents the bus snapshot taken when
// each accepted edge was first seen.
//
// state     | meaning
// ----------+---------------------------------------------------------
// LOW       | ram_clk settled low, watching for a rising edge
// RISE_PEND | rising edge seen, waiting for it to hold FILTER_LEN samples
// HIGH      | ram_clk settled high, watching for a falling edge
// FALL_PEND | falling edge seen, waiting for it to hold FILTER_LEN samples
module ram_sampler #(
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [22:0] ram_a,
  input  logic [15:0] ram_d,
  input  logic        ram_oe,
  input  logic        ram_we,
  input  logic        ram_ce1,
  input  logic        ram_ub,
  input  logic        ram_lb,
  input  logic        ram_adv,
  input  logic        ram_ce2,
  input  logic        ram_clk,
  output logic [22:0] filter_a,
  output logic [15:0] filter_d,
  output logic [1:0]  filter_ublb,
  output logic        filter_read,
  output logic        filter_write,
  output logic        filter_addr_latch,
  output logic        filter_strobe,
  output logic [15:0] nfilter_d,
  output logic        nfilter_strobe,
  output logic        err_glitch
);

  typedef struct packed {
    logic [22:0] a;
    logic [15:0] d;
    logic        oe;
    logic        we;
    logic        ce1;
    logic        ub;
    logic        lb;
    logic        adv;
    logic        ce2;
  } bus_t;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } state_t;

  // The hold counter records samples already seen at the new level; the
  // current sample is one more, so the edge is accepted once the counter
  // reaches FILTER_LEN-1 with the level still held.
  localparam logic [2:0] CNT_LAST = 3'(FILTER_LEN - 1);

  bus_t       bus_in;
  bus_t       bus_s1;
  bus_t       bus_s;
  bus_t       hold;
  bus_t       src;
  logic       clk_s1;
  logic       s_clk;
  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       snap_load;
  logic       acc_rise;
  logic       acc_fall;
  logic       glitch;
  logic       sel;
  logic       dec_latch;
  logic       dec_write;
  logic       dec_read;

  assign bus_in = {ram_a, ram_d, ram_oe, ram_we, ram_ce1, ram_ub, ram_lb, ram_adv, ram_ce2};

  // Two-flop synchronizer for every asynchronous input.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      bus_s1 <= '0;
      bus_s  <= '0;
      clk_s1 <= 1'b0;
      s_clk  <= 1'b0;
    end else begin
      bus_s1 <= bus_in;
      bus_s  <= bus_s1;
      clk_s1 <= ram_clk;
      s_clk  <= clk_s1;
    end
  end

  // State register, hold counter and first-detection snapshot.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      state <= LOW;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (snap_load) hold <= bus_s;
    end
  end

  // Next-state logic: detect, count the hold time, accept or reject.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_load = 1'b0;
    case (state)
      LOW: begin
        if (s_clk) begin
          snap_load = 1'b1;
          if (FILTER_LEN == 1) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else begin
            state_nxt = RISE_PEND;
            cnt_nxt   = 3'd1;
          end
        end
      end
      RISE_PEND: begin
        if (!s_clk) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      HIGH: begin
        if (!s_clk) begin
          snap_load = 1'b1;
          if (FILTER_LEN == 1) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else begin
            state_nxt = FALL_PEND;
            cnt_nxt   = 3'd1;
          end
        end
      end
      FALL_PEND: begin
        if (s_clk) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Acceptance/reject events and cycle-type decode of the captured sample.
  // With FILTER_LEN=1 the edge is accepted straight from LOW/HIGH, so the
  // live synchronized bus is the snapshot.
  always_comb begin
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    glitch   = 1'b0;
    src      = (state == RISE_PEND || state == FALL_PEND) ? hold : bus_s;
    case (state)
      LOW:       acc_rise = s_clk && (FILTER_LEN == 1);
      RISE_PEND: begin
        acc_rise = s_clk && (cnt == CNT_LAST);
        glitch   = !s_clk;
      end
      HIGH:      acc_fall = !s_clk && (FILTER_LEN == 1);
      FALL_PEND: begin
        acc_fall = !s_clk && (cnt == CNT_LAST);
        glitch   = s_clk;
      end
      default: ;
    endcase
    sel       = ~src.ce1 & src.ce2;
    dec_latch = sel & ~src.adv;
    dec_write = sel & src.adv & ~src.we;
    dec_read  = sel & src.adv & src.we & ~src.oe;
  end

  // Output registers: update on accepted edges, hold otherwise.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      filter_a          <= '0;
      filter_d          <= '0;
      filter_ublb       <= '0;
      filter_read       <= 1'b0;
      filter_write      <= 1'b0;
      filter_addr_latch <= 1'b0;
      filter_strobe     <= 1'b0;
      nfilter_d         <= '0;
      nfilter_strobe    <= 1'b0;
      err_glitch        <= 1'b0;
    end else begin
      filter_strobe  <= acc_rise;
      nfilter_strobe <= acc_fall;
      err_glitch     <= glitch;
      if (acc_rise) begin
        filter_a          <= src.a;
        filter_d          <= src.d;
        filter_ublb       <= {~src.ub, ~src.lb};
        filter_read       <= dec_read;
        filter_write      <= dec_write;
        filter_addr_latch <= dec_latch;
      end
      if (acc_fall) nfilter_d <= src.d;
    end
  end

endmodule

// File: tb/tb_ram_sampler.sv
// Bench for ram_sampler: three instances (FILTER_LEN 1, 2, 3) share one
// stimulus bus; a vector table drives full clean cycles, followed by
// hand-written glitch, snapshot and reset-mid-pend sequences.
module tb_ram_sampler;

  typedef struct {
    logic [22:0] a;
    logic [15:0] d;
    logic [15:0] d_fall;
    logic        oe, we, ce1, ce2, ub, lb, adv;
    logic        al, wr, rd;
    logic [1:0]  ublb;
  } vec_t;

  typedef struct packed {
    logic [22:0] a;
    logic [15:0] d;
    logic [1:0]  ublb;
    logic        rd, wr, al, fs;
    logic [15:0] nd;
    logic        nfs, gl;
  } out_t;

  logic        mclk = 1'b0;
  logic        reset = 1'b0;
  logic [22:0] ram_a = '0;
  logic [15:0] ram_d = '0;
  logic        ram_oe = 1'b1, ram_we = 1'b1, ram_ce1 = 1'b1, ram_ub = 1'b1;
  logic        ram_lb = 1'b1, ram_adv = 1'b1, ram_ce2 = 1'b0, ram_clk = 1'b0;

  logic [22:0] a1, a2, a3;
  logic [15:0] d1, d2, d3, nd1, nd2, nd3;
  logic [1:0]  ub1, ub2, ub3;
  logic        rd1, rd2, rd3, wr1, wr2, wr3, al1, al2, al3;
  logic        fs1, fs2, fs3, nfs1, nfs2, nfs3, gl1, gl2, gl3;

  out_t o [3];
  vec_t vt [7];

  int n_checks = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int fs_cnt [3] = '{0, 0, 0};
  int nfs_cnt [3] = '{0, 0, 0};
  int gl_cnt [3] = '{0, 0, 0};
  int fs_at [3] = '{0, 0, 0};
  int both_cnt = 0;
  int fs0 [3], nfs0 [3], gl0 [3];
  int k;

  initial forever #5 mclk = ~mclk;

  ram_sampler #(.FILTER_LEN(1)) dut1 (
    .mclk(mclk), .reset(reset), .ram_a(ram_a), .ram_d(ram_d), .ram_oe(ram_oe),
    .ram_we(ram_we), .ram_ce1(ram_ce1), .ram_ub(ram_ub), .ram_lb(ram_lb),
    .ram_adv(ram_adv), .ram_ce2(ram_ce2), .ram_clk(ram_clk),
    .filter_a(a1), .filter_d(d1), .filter_ublb(ub1), .filter_read(rd1),
    .filter_write(wr1), .filter_addr_latch(al1), .filter_strobe(fs1),
    .nfilter_d(nd1), .nfilter_strobe(nfs1), .err_glitch(gl1));

  ram_sampler #(.FILTER_LEN(2)) dut2 (
    .mclk(mclk), .reset(reset), .ram_a(ram_a), .ram_d(ram_d), .ram_oe(ram_oe),
    .ram_we(ram_we), .ram_ce1(ram_ce1), .ram_ub(ram_ub), .ram_lb(ram_lb),
    .ram_adv(ram_adv), .ram_ce2(ram_ce2), .ram_clk(ram_clk),
    .filter_a(a2), .filter_d(d2), .filter_ublb(ub2), .filter_read(rd2),
    .filter_write(wr2), .filter_addr_latch(al2), .filter_strobe(fs2),
    .nfilter_d(nd2), .nfilter_strobe(nfs2), .err_glitch(gl2));

  ram_sampler #(.FILTER_LEN(3)) dut3 (
    .mclk(mclk), .reset(reset), .ram_a(ram_a), .ram_d(ram_d), .ram_oe(ram_oe),
    .ram_we(ram_we), .ram_ce1(ram_ce1), .ram_ub(ram_ub), .ram_lb(ram_lb),
    .ram_adv(ram_adv), .ram_ce2(ram_ce2), .ram_clk(ram_clk),
    .filter_a(a3), .filter_d(d3), .filter_ublb(ub3), .filter_read(rd3),
    .filter_write(wr3), .filter_addr_latch(al3), .filter_strobe(fs3),
    .nfilter_d(nd3), .nfilter_strobe(nfs3), .err_glitch(gl3));

  always_comb begin
    o[0] = {a1, d1, ub1, rd1, wr1, al1, fs1, nd1, nfs1, gl1};
    o[1] = {a2, d2, ub2, rd2, wr2, al2, fs2, nd2, nfs2, gl2};
    o[2] = {a3, d3, ub3, rd3, wr3, al3, fs3, nd3, nfs3, gl3};
  end

  // Pulse monitor: counts strobes/glitches and records the posedge index
  // of the latest filter_strobe, sampled 2 ns after each rising edge.
  always begin
    @(posedge mclk);
    cyc_n++;
    #2;
    for (int i = 0; i < 3; i++) begin
      if (o[i].fs) begin
        fs_cnt[i]++;
        fs_at[i] = cyc_n;
      end
      if (o[i].nfs) nfs_cnt[i]++;
      if (o[i].gl) gl_cnt[i]++;
      if (o[i].fs && o[i].nfs) both_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      fs0[i] = fs_cnt[i];
      nfs0[i] = nfs_cnt[i];
      gl0[i] = gl_cnt[i];
    end
  endtask

  function automatic vec_t mk(input logic [22:0] a, input logic [15:0] d, input logic [15:0] df,
                              input logic oe, input logic we, input logic ce1, input logic ce2,
                              input logic ub, input logic lb, input logic adv,
                              input logic al, input logic wr, input logic rd, input logic [1:0] ublb);
    vec_t t;
    t.a = a; t.d = d; t.d_fall = df;
    t.oe = oe; t.we = we; t.ce1 = ce1; t.ce2 = ce2; t.ub = ub; t.lb = lb; t.adv = adv;
    t.al = al; t.wr = wr; t.rd = rd; t.ublb = ublb;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    ram_a = t.a; ram_d = t.d; ram_oe = t.oe; ram_we = t.we; ram_ce1 = t.ce1;
    ram_ce2 = t.ce2; ram_ub = t.ub; ram_lb = t.lb; ram_adv = t.adv;
  endtask

  task automatic check_out(input int i, input string tag, input vec_t t);
    check($sformatf("%s dut%0d filter_a", tag, i + 1), 32'(o[i].a), 32'(t.a));
    check($sformatf("%s dut%0d filter_d", tag, i + 1), 32'(o[i].d), 32'(t.d));
    check($sformatf("%s dut%0d filter_ublb", tag, i + 1), 32'(o[i].ublb), 32'(t.ublb));
    check($sformatf("%s dut%0d flags{al,wr,rd}", tag, i + 1),
          32'({o[i].al, o[i].wr, o[i].rd}), 32'({t.al, t.wr, t.rd}));
  endtask

  task automatic check_zero(input int i, input string tag);
    check($sformatf("%s dut%0d all outputs zero", tag, i + 1), 32'(o[i] != '0), 32'd0);
  endtask

  initial begin
    //        a            d         d_fall    oe we c1 c2 ub lb adv  al wr rd ublb
    vt[0] = mk(23'h012345, 16'h0000, 16'h0000, 1, 1, 0, 1, 1, 1, 0,   1, 0, 0, 2'b00);
    vt[1] = mk(23'h000100, 16'hBEEF, 16'h1234, 1, 0, 0, 1, 0, 1, 1,   0, 1, 0, 2'b10);
    vt[2] = mk(23'h7FFFFF, 16'h5A5A, 16'hA5A5, 0, 1, 0, 1, 0, 0, 1,   0, 0, 1, 2'b11);
    vt[3] = mk(23'h2AAAAA, 16'h0F0F, 16'hF0F0, 0, 1, 0, 0, 1, 0, 1,   0, 0, 0, 2'b01);
    vt[4] = mk(23'h555555, 16'hFFFF, 16'h0001, 0, 0, 1, 1, 0, 1, 0,   0, 0, 0, 2'b10);
    vt[5] = mk(23'h400000, 16'h8001, 16'h7FFE, 0, 0, 0, 1, 1, 1, 1,   0, 1, 0, 2'b00);
    vt[6] = mk(23'h000001, 16'h1357, 16'h2468, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 2'b11);

    reset = 1'b0;
    ram_clk = 1'b0;
    cyc(3);
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    reset = 1'b1;
    cyc(2);

    // Clean rise/fall cycles from the table.
    for (int v = 0; v < 7; v++) begin
      apply(vt[v]);
      ram_clk = 1'b0;
      cyc(4);
      snap();
      k = cyc_n;
      ram_clk = 1'b1;
      cyc(8);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("v%0d dut%0d strobe count", v, i + 1), 32'(fs_cnt[i] - fs0[i]), 32'd1);
        check($sformatf("v%0d dut%0d strobe latency", v, i + 1), 32'(fs_at[i]), 32'(k + 3 + i));
        check($sformatf("v%0d dut%0d no glitch", v, i + 1), 32'(gl_cnt[i] - gl0[i]), 32'd0);
        check_out(i, $sformatf("v%0d", v), vt[v]);
      end
      ram_d = vt[v].d_fall;
      ram_clk = 1'b0;
      cyc(8);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("v%0d dut%0d nstrobe count", v, i + 1), 32'(nfs_cnt[i] - nfs0[i]), 32'd1);
        check($sformatf("v%0d dut%0d nfilter_d", v, i + 1), 32'(o[i].nd), 32'(vt[v].d_fall));
        check($sformatf("v%0d dut%0d filter_d hold", v, i + 1), 32'(o[i].d), 32'(vt[v].d));
      end
    end

    // Rising glitch: one mclk cycle high.
    apply(mk(23'h111111, 16'h2222, 16'h0000, 1, 1, 0, 1, 1, 1, 0, 1, 0, 0, 2'b00));
    cyc(4);
    snap();
    ram_clk = 1'b1;
    cyc(1);
    ram_clk = 1'b0;
    cyc(8);
    for (int i = 1; i < 3; i++) begin
      check($sformatf("rglitch dut%0d strobe count", i + 1), 32'(fs_cnt[i] - fs0[i]), 32'd0);
      check($sformatf("rglitch dut%0d glitch count", i + 1), 32'(gl_cnt[i] - gl0[i]), 32'd1);
      check($sformatf("rglitch dut%0d filter_a hold", i + 1), 32'(o[i].a), 32'h000001);
      check($sformatf("rglitch dut%0d filter_d hold", i + 1), 32'(o[i].d), 32'h1357);
    end
    check("rglitch dut1 strobe count", 32'(fs_cnt[0] - fs0[0]), 32'd1);
    check("rglitch dut1 nstrobe count", 32'(nfs_cnt[0] - nfs0[0]), 32'd1);
    check("rglitch dut1 glitch count", 32'(gl_cnt[0] - gl0[0]), 32'd0);
    check("rglitch dut1 filter_a", 32'(o[0].a), 32'h111111);

    // Falling glitch: settle high, then one mclk cycle low.
    ram_clk = 1'b1;
    cyc(8);
    snap();
    ram_d = 16'h3333;
    ram_clk = 1'b0;
    cyc(1);
    ram_clk = 1'b1;
    cyc(8);
    for (int i = 1; i < 3; i++) begin
      check($sformatf("fglitch dut%0d nstrobe count", i + 1), 32'(nfs_cnt[i] - nfs0[i]), 32'd0);
      check($sformatf("fglitch dut%0d strobe count", i + 1), 32'(fs_cnt[i] - fs0[i]), 32'd0);
      check($sformatf("fglitch dut%0d glitch count", i + 1), 32'(gl_cnt[i] - gl0[i]), 32'd1);
      check($sformatf("fglitch dut%0d nfilter_d hold", i + 1), 32'(o[i].nd), 32'h2468);
    end
    check("fglitch dut1 nstrobe count", 32'(nfs_cnt[0] - nfs0[0]), 32'd1);
    check("fglitch dut1 nfilter_d", 32'(o[0].nd), 32'h3333);
    ram_clk = 1'b0;
    cyc(8);
    check("fglitch dut2 later fall", 32'(o[1].nd), 32'h3333);

    // Snapshot: data changes one cycle after the clock edge.
    apply(mk(23'h0F0F0F, 16'hAAAA, 16'h0000, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 2'b11));
    cyc(4);
    snap();
    ram_clk = 1'b1;
    cyc(1);
    ram_d = 16'h5555;
    cyc(8);
    for (int i = 0; i < 3; i++)
      check($sformatf("snapshot dut%0d filter_d", i + 1), 32'(o[i].d), 32'hAAAA);
    check("snapshot dut3 strobe count", 32'(fs_cnt[2] - fs0[2]), 32'd1);
    ram_clk = 1'b0;
    cyc(8);
    check("snapshot dut3 nfilter_d", 32'(o[2].nd), 32'h5555);

    // Reset one cycle into RISE_PEND, then recovery with ram_clk held high.
    apply(mk(23'h0ABCDE, 16'hC0DE, 16'h0000, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 2'b11));
    cyc(4);
    snap();
    ram_clk = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    for (int i = 1; i < 3; i++) begin
      check($sformatf("rstpend dut%0d strobe count", i + 1), 32'(fs_cnt[i] - fs0[i]), 32'd0);
      check($sformatf("rstpend dut%0d glitch count", i + 1), 32'(gl_cnt[i] - gl0[i]), 32'd0);
    end
    for (int i = 0; i < 3; i++) check_zero(i, "rstpend");
    snap();
    k = cyc_n;
    reset = 1'b1;
    cyc(8);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("recover dut%0d strobe count", i + 1), 32'(fs_cnt[i] - fs0[i]), 32'd1);
      check($sformatf("recover dut%0d strobe latency", i + 1), 32'(fs_at[i]), 32'(k + 3 + i));
      check($sformatf("recover dut%0d glitch count", i + 1), 32'(gl_cnt[i] - gl0[i]), 32'd0);
      check_out(i, "recover", mk(23'h0ABCDE, 16'hC0DE, 16'h0000, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 2'b11));
    end
    ram_clk = 1'b0;
    cyc(8);
    check("recover dut2 nfilter_d", 32'(o[1].nd), 32'hC0DE);
    check("strobe and nstrobe never together", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
